// File: rtl/priority_encode_seq.sv
// Registered N-to-log2(N) priority encoder with pending-request capture and a valid/ready output.
// Define ENCODE_RR_EN to build rotating priority; otherwise the lowest pending index always wins.
module priority_encode_seq #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic         out_valid,
    output logic         busy,
    output logic         drop
);

    logic [N-1:0] pend_q, pend_d;
    logic [W-1:0] out_q, out_d;
    logic         out_valid_q, out_valid_d;
    logic         drop_q, drop_d;

    logic [N-1:0] req_en;
    logic [N-1:0] load_mask;
    logic [W-1:0] sel_idx;
    logic         load;

    assign req_en = en ? req : '0;
    assign load   = (pend_q != '0) && (!out_valid_q || out_ready);

`ifdef ENCODE_RR_EN
    logic [W-1:0] rr_ptr_q;

    // Search starts at rr_ptr; W-bit addition wraps N-1 back to 0 because N is a power of 2.
    always_comb begin
        logic         found;
        logic [W-1:0] idx;
        sel_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = rr_ptr_q + W'(k);
            if (!found && pend_q[idx]) begin
                sel_idx = idx;
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else if (load) begin
            rr_ptr_q <= sel_idx + W'(1);
        end
    end
`else
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        logic found;
        sel_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && pend_q[i]) begin
                sel_idx = W'(i);
                found   = 1'b1;
            end
        end
    end
`endif

    assign load_mask = load ? (N'(1) << sel_idx) : '0;

    always_comb begin
        // A fresh request for the bit being loaded re-arms it: set wins over clear.
        pend_d      = (pend_q & ~load_mask) | req_en;
        drop_d      = |(req_en & pend_q & ~load_mask);
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_d       = sel_idx;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            drop_q      <= drop_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign drop      = drop_q;
    assign busy      = (pend_q != '0) || out_valid_q;

endmodule

// File: tb/tb_priority_encode_seq.sv
// Self-checking bench for priority_encode_seq (N=4): directed scenarios, then random traffic
// compared cycle by cycle against a set-based reference model.
module tb_priority_encode_seq;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic       out_ready;
    logic [1:0] out;
    logic       out_valid;
    logic       busy;
    logic       drop;

    int checks   = 0;
    int failures = 0;
    int xfers2   = 0;

    // Reference model: pending set, output slot, drop flag, search start.
    bit m_pend[N];
    int m_out;
    bit m_valid;
    bit m_drop;
    int m_rr;
    bit n_pend[N];
    int n_out;
    bit n_valid;
    bit n_drop;
    int n_rr;

    priority_encode_seq #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .req      (req),
        .out_ready(out_ready),
        .out      (out),
        .out_valid(out_valid),
        .busy     (busy),
        .drop     (drop)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_busy();
        bit b = m_valid;
        for (int i = 0; i < N; i++) if (m_pend[i]) b = 1'b1;
        return b;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_out   = 0;
        m_valid = 1'b0;
        m_drop  = 1'b0;
        m_rr    = 0;
    endfunction

    // One clock of behaviour from the rules: pick a pending line if the output slot is free.
    function automatic void model_next();
        int pick = -1;
        if (!m_valid || out_ready) begin
            for (int k = 0; k < N; k++) begin
                int i = (m_rr + k) % N;
                if (pick < 0 && m_pend[i]) pick = i;
            end
        end
        n_drop = 1'b0;
        for (int i = 0; i < N; i++) begin
            bit fresh = en && req[i];
            bit keep  = m_pend[i] && (i != pick);
            n_pend[i] = keep || fresh;
            if (fresh && keep) n_drop = 1'b1;
        end
        n_out   = m_out;
        n_valid = m_valid;
        n_rr    = m_rr;
        if (pick >= 0) begin
            n_out   = pick;
            n_valid = 1'b1;
`ifdef ENCODE_RR_EN
            n_rr    = (pick + 1) % N;
`endif
        end else if (out_ready) begin
            n_valid = 1'b0;
        end
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".out"},       32'(out),       32'(m_out));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".busy"},      32'(busy),      32'(model_busy()));
        check({tag, ".drop"},      32'(drop),      32'(m_drop));
    endtask

    task automatic tick(input string tag);
        model_next();
        if (out_valid === 1'b1 && out_ready && out === 2'd2) xfers2++;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) m_pend[i] = n_pend[i];
        m_out   = n_out;
        m_valid = n_valid;
        m_drop  = n_drop;
        m_rr    = n_rr;
        check_all(tag);
    endtask

    // Asserts reset mid-cycle and checks outputs before any clock edge can occur.
    task automatic apply_reset(input string tag);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        check({tag, ".busy0"}, 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        en        = 1'b0;
        req       = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        #2;
        check_all("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Two requests in one pulse drain in priority order.
        en = 1'b1; req = 4'b1010; out_ready = 1'b1;
        tick("t2.cap");
        req = '0;
        tick("t2.a");
        check("t2.first", 32'(out), 32'd1);
        tick("t2.b");
        check("t2.second", 32'(out), 32'd3);
        tick("t2.c");
        check("t2.idle", 32'({out_valid, busy}), 32'd0);

        // Asynchronous reset while an index is held and lines are pending.
        out_ready = 1'b0; req = 4'b1011;
        tick("t1.cap");
        req = 4'b0001;
        tick("t1.hold");
        check("t1.valid_before", 32'(out_valid), 32'd1);
        req = '0;
        apply_reset("t1.rst");

        // Repeated request for a held index: first re-arms, second is merged.
        en = 1'b1; out_ready = 1'b0; req = 4'b0100;
        tick("t3.cap");
        req = '0;
        tick("t3.held");
        check("t3.out2", 32'(out), 32'd2);
        req = 4'b0100;
        tick("t3.rearm");
        check("t3.nodrop", 32'(drop), 32'd0);
        tick("t3.merge");
        check("t3.drop", 32'(drop), 32'd1);
        req = '0;
        tick("t3.pulse");
        check("t3.drop_end", 32'(drop), 32'd0);
        xfers2 = 0;
        out_ready = 1'b1;
        tick("t3.x1");
        tick("t3.x2");
        tick("t3.x3");
        check("t3.delivered", 32'(xfers2), 32'd2);

        // Capture disabled.
        en = 1'b0; req = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            tick("t4.dis");
            check("t4.quiet", 32'({out_valid, busy, drop}), 32'd0);
        end

        // Continuous requests on every line.
        apply_reset("t5.rst");
        en = 1'b1; req = 4'b1111; out_ready = 1'b1;
        tick("t5.cap");
        for (int j = 0; j < 6; j++) begin
            tick("t5.run");
            check("t5.valid", 32'(out_valid), 32'd1);
`ifdef ENCODE_RR_EN
            check("t5.seq", 32'(out), 32'(j % N));
`else
            check("t5.seq", 32'(out), 32'd0);
`endif
        end
        req = '0;
        for (int c = 0; c < 5; c++) tick("t5.drain");

        // Transfer and next load in the same cycle: no bubble.
        out_ready = 1'b0; req = 4'b0001;
        tick("t6.cap");
        req = '0;
        tick("t6.held");
        req = 4'b0001;
        tick("t6.pend");
        req = '0; out_ready = 1'b1;
        tick("t6.b2b");
        check("t6.b2b", 32'({out_valid, out}), 32'({1'b1, 2'd0}));
        tick("t6.end");

        // Random traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            en        = ($urandom_range(0, 7) != 0);
            req       = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 63) == 0) apply_reset("rnd.rst");
            else tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
